mask_cmd_loader: RTL and testbench
==================================

MASK_CMD_LOADER -- requirements
Module: mask_cmd_loader

Interface
REQ-001 SHALL have ports: clk_sys  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: ioctl_download  in  1  mask-file download window (already index-qualified).
REQ-004 SHALL have: ioctl_wr  in  1  one-cycle strobe, ioctl_dout valid.
REQ-005 SHALL have: ioctl_addr  in  11  byte address; word index = ioctl_addr[10:1].
REQ-006 SHALL have: ioctl_dout  in  16  file word.
REQ-007 SHALL have: ioctl_wait  out  1  backpressure to downloader.
REQ-008 SHALL have: mask_on  in  1  user enable for the mask.
REQ-009 SHALL have: cmd_wr  out  1  one-cycle command strobe to the shadow-mask stage.
REQ-010 SHALL have: cmd_in  out  16  command word: [15:13] opcode, payload below.
REQ-011 SHALL have: loaded  out  1  valid mask programmed.
REQ-012 SHALL have: error  out  2  00 none, 01 bad magic, 10 short file, 11 bad geometry.

Function
REQ-013 File format SHALL be: word0 magic 16'h4D41; word1 {6'b0, rotate, x2, vmax[3:0], hmax[3:0]}; then N = (hmax+1)*(vmax+1) LUT words, bits [10:0] used.
REQ-014 Input words SHALL enter a 4-entry FIFO on ioctl_wr while ioctl_download=1; ioctl_wait SHALL be 1 whenever FIFO count >= 2.
REQ-015 FSM states SHALL be IDLE, MAGIC, GEOM, CMD_V, CMD_H, BODY, FINISH, DONE, FAIL.
REQ-016 Rising edge of ioctl_download SHALL clear loaded and error, flush FIFO, enter MAGIC from any state.
REQ-017 MAGIC: pop word; mismatch -> error=01, FAIL; match -> GEOM.
REQ-018 GEOM: pop word; N>256 impossible, but word[15:10]!=0 -> error=11, FAIL; else latch fields, emit {3'b000,9'b0,1'b0(enable),rotate,x2,1'b0}, go CMD_V.
REQ-019 CMD_V SHALL emit {3'b001,9'b0,vmax}; CMD_H SHALL emit {3'b010,9'b0,hmax}; each one cycle, no pop.
REQ-020 BODY: each popped word SHALL emit {3'b011,2'b00,word[10:0]}; 8-bit entry counter, after the Nth entry -> FINISH.
REQ-021 FINISH SHALL emit {3'b000,9'b0,mask_on,rotate,x2,1'b0}, set loaded=1, go DONE.
REQ-022 At most one cmd_wr per cycle; cmd_in/cmd_wr registered; cmd_wr asserted exactly one cycle after the pop (or state entry) that produces it.
REQ-023 Words beyond N and words arriving in FAIL/DONE SHALL be popped and discarded.
REQ-024 Falling ioctl_download while in MAGIC..BODY with FIFO empty SHALL set error=10, enter FAIL; no enable command issued.
REQ-025 In DONE with ioctl_download=0, a change of mask_on SHALL emit the FINISH-form command within 2 cycles; simultaneous download start SHALL take priority.
REQ-026 cmd_in SHALL hold its last value when cmd_wr=0.

Reset
REQ-027 Reset SHALL force IDLE, FIFO empty, cmd_wr=0, cmd_in=0, ioctl_wait=0, loaded=0, error=00, mid-file or not; no command emitted on reset cycle or after.

Structure
REQ-028 Shared package SHALL hold magic constant, 3-bit opcodes (CFG, VMAX, HMAX, LUT), FSM state enum, error codes.
REQ-029 FIFO SHALL be one sub-module mask_word_fifo (depth 4, width 16, count output).

Verification
REQ-030 File 4D41,0011,600,500,400,300 (2x2, no rotate/x2), mask_on=1 -> cmd_in 0000,2001,4001,6600,6500,6400,6300,0008; loaded=1, error=00.
REQ-031 Word0=1234 -> no cmd_wr, error=01, loaded=0; subsequent words discarded.
REQ-032 1x1 file truncated after word1, download drops -> cmds 0000,2000,4000 only, error=10.
REQ-033 Loaded, mask_on 1->0 -> single cmd_wr with cmd_in=0000 (rotate=0,x2=0) within 2 cycles.
REQ-034 ioctl_wr every cycle for full 16x16 file -> ioctl_wait asserts, no word lost, 256 LUT cmds counted.
REQ-035 Reset asserted mid-BODY -> cmd_wr=0 next cycle, state IDLE, loaded=0.

Source files
------------

// File: rtl/mask_cmd_loader_pkg.sv
// Shared constants, opcodes, FSM states and error codes for the shadow-mask file loader.
package mask_cmd_loader_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 3;

    localparam logic [WORD_W-1:0] MASK_MAGIC = 16'h4D41;

    typedef enum logic [2:0] {
        OP_CFG  = 3'b000,
        OP_VMAX = 3'b001,
        OP_HMAX = 3'b010,
        OP_LUT  = 3'b011
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MAGIC,
        S_GEOM,
        S_CMD_V,
        S_CMD_H,
        S_BODY,
        S_FINISH,
        S_DONE,
        S_FAIL
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_MAGIC = 2'b01,
        ERR_SHORT = 2'b10,
        ERR_GEOM  = 2'b11
    } err_e;

    // Layout of the geometry header word
    typedef struct packed {
        logic [5:0] rsvd;
        logic       rotate;
        logic       x2;
        logic [3:0] vmax;
        logic [3:0] hmax;
    } geom_t;

    function automatic logic [WORD_W-1:0] cfg_cmd(input logic enable, input logic rotate,
                                                   input logic x2);
        cfg_cmd = {OP_CFG, 9'b0, enable, rotate, x2, 1'b0};
    endfunction

    // Index of the last LUT entry: (hmax+1)*(vmax+1)-1, at most 255
    function automatic logic [7:0] lut_last(input logic [3:0] vmax, input logic [3:0] hmax);
        logic [8:0] n;
        n = (9'(vmax) + 9'd1) * (9'(hmax) + 9'd1);
        lut_last = 8'(n - 9'd1);
    endfunction

endpackage

// File: rtl/mask_word_fifo.sv
// 4-deep show-ahead word FIFO with flush and a registered "two or more" flag.
module mask_word_fifo
    import mask_cmd_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] din,
    input  logic              pop,
    output logic [WORD_W-1:0] head_c,
    output logic              empty_c,
    output logic [CNT_W-1:0]  count,
    output logic              half_full
);

    localparam int unsigned PTR_W = 2;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_idx;
    logic              do_push;
    logic              do_pop;
    logic [CNT_W-1:0]  count_next;

    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];

    // A flush empties the FIFO but still accepts a same-cycle write into slot 0
    always_comb begin
        do_pop  = pop && !empty_c && !flush;
        do_push = push && (flush || (count != CNT_W'(FIFO_DEPTH)));
        wr_idx  = flush ? '0 : wr_ptr;
        if (flush) begin
            count_next = CNT_W'(do_push);
        end else begin
            count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            half_full <= 1'b0;
        end else begin
            wr_ptr    <= wr_idx + PTR_W'(do_push);
            rd_ptr    <= flush ? '0 : rd_ptr + PTR_W'(do_pop);
            count     <= count_next;
            half_full <= (count_next >= CNT_W'(2));
        end
    end

endmodule

// File: rtl/mask_cmd_loader.sv
// Parses a downloaded shadow-mask file and replays it as a stream of 16-bit
// configuration commands to the shadow-mask stage.
module mask_cmd_loader
    import mask_cmd_loader_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [WORD_W-1:0] ioctl_dout,
    output logic              ioctl_wait,
    input  logic              mask_on,
    output logic              cmd_wr,
    output logic [WORD_W-1:0] cmd_in,
    output logic              loaded,
    output logic [1:0]        error
);

    state_e            state;
    logic              dl_q;
    logic              mask_q;
    logic              rotate;
    logic              x2;
    logic [3:0]        vmax;
    logic [3:0]        hmax;
    logic [7:0]        entry_cnt;
    logic [7:0]        entry_last;

    logic              dl_rise;
    logic              starved_c;
    logic              pop_c;
    logic              empty_c;
    logic [WORD_W-1:0] head_c;
    logic [CNT_W-1:0]  fifo_count;
    geom_t             geom_c;
    logic              obs_unused;

    // Words arrive strictly in order, so the address and fill level are informational only
    assign obs_unused = ^{ioctl_addr, fifo_count};

    assign dl_rise   = ioctl_download && !dl_q;
    assign starved_c = !ioctl_download && empty_c;
    assign geom_c    = geom_t'(head_c);

    mask_word_fifo u_fifo (
        .clk       (clk_sys),
        .reset     (reset),
        .flush     (dl_rise),
        .push      (ioctl_wr && ioctl_download),
        .din       (ioctl_dout),
        .pop       (pop_c),
        .head_c    (head_c),
        .empty_c   (empty_c),
        .count     (fifo_count),
        .half_full (ioctl_wait)
    );

    // States that consume words; IDLE/DONE/FAIL consume only to discard
    always_comb begin
        pop_c = 1'b0;
        if (!dl_rise && !empty_c) begin
            case (state)
                S_IDLE, S_MAGIC, S_GEOM, S_BODY, S_DONE, S_FAIL: pop_c = 1'b1;
                default: pop_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            dl_q       <= ioctl_download;
            mask_q     <= 1'b0;
            rotate     <= 1'b0;
            x2         <= 1'b0;
            vmax       <= '0;
            hmax       <= '0;
            entry_cnt  <= '0;
            entry_last <= '0;
            cmd_wr     <= 1'b0;
            cmd_in     <= '0;
            loaded     <= 1'b0;
            error      <= ERR_NONE;
        end else begin
            dl_q   <= ioctl_download;
            cmd_wr <= 1'b0;
            if (dl_rise) begin
                state  <= S_MAGIC;
                loaded <= 1'b0;
                error  <= ERR_NONE;
            end else begin
                case (state)
                    S_MAGIC: begin
                        if (pop_c) begin
                            if (head_c == MASK_MAGIC) begin
                                state <= S_GEOM;
                            end else begin
                                error <= ERR_MAGIC;
                                state <= S_FAIL;
                            end
                        end else if (starved_c) begin
                            error <= ERR_SHORT;
                            state <= S_FAIL;
                        end
                    end
                    S_GEOM: begin
                        if (pop_c) begin
                            if (geom_c.rsvd != '0) begin
                                error <= ERR_GEOM;
                                state <= S_FAIL;
                            end else begin
                                rotate     <= geom_c.rotate;
                                x2         <= geom_c.x2;
                                vmax       <= geom_c.vmax;
                                hmax       <= geom_c.hmax;
                                entry_cnt  <= '0;
                                entry_last <= lut_last(geom_c.vmax, geom_c.hmax);
                                cmd_wr     <= 1'b1;
                                cmd_in     <= cfg_cmd(1'b0, geom_c.rotate, geom_c.x2);
                                state      <= S_CMD_V;
                            end
                        end else if (starved_c) begin
                            error <= ERR_SHORT;
                            state <= S_FAIL;
                        end
                    end
                    S_CMD_V: begin
                        cmd_wr <= 1'b1;
                        cmd_in <= {OP_VMAX, 9'b0, vmax};
                        state  <= S_CMD_H;
                    end
                    S_CMD_H: begin
                        cmd_wr <= 1'b1;
                        cmd_in <= {OP_HMAX, 9'b0, hmax};
                        state  <= S_BODY;
                    end
                    S_BODY: begin
                        if (pop_c) begin
                            cmd_wr <= 1'b1;
                            cmd_in <= {OP_LUT, 2'b00, head_c[10:0]};
                            if (entry_cnt == entry_last) begin
                                state <= S_FINISH;
                            end else begin
                                entry_cnt <= entry_cnt + 8'd1;
                            end
                        end else if (starved_c) begin
                            error <= ERR_SHORT;
                            state <= S_FAIL;
                        end
                    end
                    S_FINISH: begin
                        cmd_wr <= 1'b1;
                        cmd_in <= cfg_cmd(mask_on, rotate, x2);
                        mask_q <= mask_on;
                        loaded <= 1'b1;
                        state  <= S_DONE;
                    end
                    S_DONE: begin
                        // Live user toggle re-issues the enable command
                        if (!ioctl_download && (mask_on != mask_q)) begin
                            cmd_wr <= 1'b1;
                            cmd_in <= cfg_cmd(mask_on, rotate, x2);
                            mask_q <= mask_on;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mask_cmd_loader.sv
// Directed bench for mask_cmd_loader: table of whole files plus toggle, stress and reset sequences.
module tb_mask_cmd_loader;
    import mask_cmd_loader_pkg::*;

    typedef struct {
        string            name;
        int               nw;
        logic [0:7][15:0] w;
        logic             mask;
        int               nc;
        logic [0:7][15:0] c;
        logic             ld;
        logic [1:0]       err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [10:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic        mask_on;
    logic        cmd_wr;
    logic [15:0] cmd_in;
    logic        loaded;
    logic [1:0]  error;

    vec_t        vecs[6];
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    int          applied = 0;
    int          miscompares = 0;
    logic        saw_wait;

    always #5 clk = ~clk;

    mask_cmd_loader dut (
        .clk_sys        (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mask_on        (mask_on),
        .cmd_wr         (cmd_wr),
        .cmd_in         (cmd_in),
        .loaded         (loaded),
        .error          (error)
    );

    always @(negedge clk) begin
        if (cmd_wr) rx_q.push_back(cmd_in);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [15:0] big_word(input int i);
        return 16'(i * 37) ^ 16'hA800;
    endfunction

    // Feeds tx_q to the DUT one word per cycle, honouring ioctl_wait
    task automatic push_all();
        int idx = 0;
        int guard = 0;
        while (tx_q.size() > 0 && guard < 4000) begin
            @(negedge clk);
            if (ioctl_wait) begin
                saw_wait = 1'b1;
                ioctl_wr = 1'b0;
            end else begin
                ioctl_wr   = 1'b1;
                ioctl_dout = tx_q.pop_front();
                ioctl_addr = 11'(idx * 2);
                idx++;
            end
            guard++;
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
        if (tx_q.size() != 0) begin
            applied++;
            miscompares++;
            $display("FAIL push_timeout: %0d words left, expected 0", tx_q.size());
        end
    endtask

    task automatic start_download(input logic m);
        mask_on = m;
        repeat (3) @(negedge clk);
        rx_q.delete();
        saw_wait = 1'b0;
        ioctl_download = 1'b1;
    endtask

    task automatic run_vec(input int k);
        tx_q.delete();
        for (int i = 0; i < vecs[k].nw; i++) tx_q.push_back(vecs[k].w[i]);
        start_download(vecs[k].mask);
        push_all();
        ioctl_download = 1'b0;
        repeat (20) @(negedge clk);
        check($sformatf("%s ncmd", vecs[k].name), 32'(rx_q.size()), 32'(vecs[k].nc));
        for (int i = 0; i < vecs[k].nc; i++)
            check($sformatf("%s cmd%0d", vecs[k].name, i), rx_at(i), 32'(vecs[k].c[i]));
        check($sformatf("%s loaded", vecs[k].name), 32'(loaded), 32'(vecs[k].ld));
        check($sformatf("%s error", vecs[k].name), 32'(error), 32'(vecs[k].err));
    endtask

    initial begin
        vecs[0] = '{"basic_2x2", 6,
                    {16'h4D41, 16'h0011, 16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0, 16'h0},
                    1'b1, 8,
                    {16'h0000, 16'h2001, 16'h4001, 16'h6600, 16'h6500, 16'h6400, 16'h6300, 16'h0008},
                    1'b1, 2'b00};
        vecs[1] = '{"bad_magic", 3,
                    {16'h1234, 16'h0011, 16'h0600, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    1'b1, 0, 128'h0, 1'b0, 2'b01};
        vecs[2] = '{"short_1x1", 2,
                    {16'h4D41, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    1'b0, 3,
                    {16'h0000, 16'h2000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    1'b0, 2'b10};
        vecs[3] = '{"bad_geom", 2,
                    {16'h4D41, 16'h0411, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    1'b0, 0, 128'h0, 1'b0, 2'b11};
        vecs[4] = '{"rot_x2_1x2_extra", 5,
                    {16'h4D41, 16'h0310, 16'h07FF, 16'hF123, 16'hAAAA, 16'h0, 16'h0, 16'h0},
                    1'b0, 6,
                    {16'h0006, 16'h2001, 16'h4000, 16'h67FF, 16'h6123, 16'h0006, 16'h0, 16'h0},
                    1'b1, 2'b00};
        vecs[5] = '{"rot_1x1_on", 3,
                    {16'h4D41, 16'h0200, 16'h0555, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    1'b1, 5,
                    {16'h0004, 16'h2000, 16'h4000, 16'h6555, 16'h000C, 16'h0, 16'h0, 16'h0},
                    1'b1, 2'b00};

        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        mask_on = 1'b0;
        saw_wait = 1'b0;
        repeat (3) @(negedge clk);
        check("rst cmd_wr", 32'(cmd_wr), 32'd0);
        check("rst cmd_in", 32'(cmd_in), 32'd0);
        check("rst ioctl_wait", 32'(ioctl_wait), 32'd0);
        check("rst loaded", 32'(loaded), 32'd0);
        check("rst error", 32'(error), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(k);

        // Loaded 2x2 mask, user turns it off
        run_vec(0);
        @(negedge clk);
        rx_q.delete();
        mask_on = 1'b0;
        repeat (2) @(negedge clk);
        check("toggle ncmd", 32'(rx_q.size()), 32'd1);
        check("toggle cmd", rx_at(0), 32'h0000);
        repeat (4) @(negedge clk);
        check("toggle single", 32'(rx_q.size()), 32'd1);
        check("toggle loaded", 32'(loaded), 32'd1);

        // Full 16x16 file streamed back-to-back
        tx_q.delete();
        tx_q.push_back(16'h4D41);
        tx_q.push_back(16'h00FF);
        for (int i = 0; i < 256; i++) tx_q.push_back(big_word(i));
        start_download(1'b1);
        push_all();
        ioctl_download = 1'b0;
        repeat (20) @(negedge clk);
        check("big ncmd", 32'(rx_q.size()), 32'd260);
        check("big cfg", rx_at(0), 32'h0000);
        check("big vmax", rx_at(1), 32'h200F);
        check("big hmax", rx_at(2), 32'h400F);
        for (int i = 0; i < 256; i++)
            check($sformatf("big lut%0d", i), rx_at(3 + i),
                  32'(16'h6000 | (big_word(i) & 16'h07FF)));
        check("big finish", rx_at(259), 32'h0008);
        check("big saw_wait", 32'(saw_wait), 32'd1);
        check("big loaded", 32'(loaded), 32'd1);
        check("big error", 32'(error), 32'd0);

        // Reset in the middle of the LUT body
        tx_q.delete();
        tx_q.push_back(16'h4D41);
        tx_q.push_back(16'h00FF);
        for (int i = 0; i < 10; i++) tx_q.push_back(big_word(i));
        start_download(1'b1);
        push_all();
        repeat (2) @(negedge clk);
        check("mid state body", 32'(dut.state), 32'(S_BODY));
        reset = 1'b1;
        @(negedge clk);
        check("mid cmd_wr", 32'(cmd_wr), 32'd0);
        check("mid state idle", 32'(dut.state), 32'(S_IDLE));
        check("mid loaded", 32'(loaded), 32'd0);
        check("mid error", 32'(error), 32'd0);
        check("mid ioctl_wait", 32'(ioctl_wait), 32'd0);
        reset = 1'b0;
        rx_q.delete();
        repeat (5) @(negedge clk);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk);
        check("post rst no cmd", 32'(rx_q.size()), 32'd0);
        check("post rst idle", 32'(dut.state), 32'(S_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
